// File: rtl/anton_neopixel_rx_pkg.sv
// anton_neopixel_rx_pkg
//   Shared definitions for the NeoPixel receiver:
//   - rx_state_t     : 2-bit receiver FSM encodings (SYNC / IDLE / HIGH / LOW)
//   - ERR_*          : error codes reported on last_err when the optional
//                      error counter (NEOPIXEL_RX_ERR_CNT_EN) is built in
//   - clog2()        : ceiling log2 used to size counters and addresses
//   - wire_to_brg()  : re-pack a wire-order {G,R,B} word into {B,R,G}
package anton_neopixel_rx_pkg;

  typedef enum logic [1:0] {
    ENUM_RX_SYNC = 2'd0,
    ENUM_RX_IDLE = 2'd1,
    ENUM_RX_HIGH = 2'd2,
    ENUM_RX_LOW  = 2'd3
  } rx_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_LONG_HIGH = 2'd1;
  localparam logic [1:0] ERR_PARTIAL   = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

  // Index of the last bit of a 24-bit pixel.
  localparam logic [4:0] BIT_LAST = 5'd23;

  // Ceiling log2, never smaller than 1 so every derived vector has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Wire order is G7..G0, R7..R0, B7..B0; the pixel buffer stores {B,R,G}.
  function automatic logic [23:0] wire_to_brg(input logic [23:0] wire_word);
    return {wire_word[7:0], wire_word[15:8], wire_word[23:16]};
  endfunction

endpackage

// File: rtl/anton_sync_edge.sv
// anton_sync_edge
//   Two-flop synchronizer for an asynchronous input followed by a registered
//   edge detector. rise/fall pulse for one clock, three clocks after the pad
//   edge; level is the synchronized input aligned with those pulses, so a
//   width counted on level matches the distance between rise and fall.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   din    in  asynchronous input
//   level  out synchronized level (aligned with rise/fall)
//   rise   out one-cycle pulse on a 0->1 transition
//   fall   out one-cycle pulse on a 1->0 transition
module anton_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // Synchronizer chain plus one delay stage for edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      dly_r  <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  // Registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync_r & ~dly_r;
      fall <= ~sync_r & dly_r;
    end
  end

  assign level = dly_r;

endmodule

// File: rtl/anton_neopixel_rx.sv
// anton_neopixel_rx
//   Decodes the single-wire NeoPixel stream into 24-bit pixels. A bit is a
//   high pulse whose width selects 0/1; a long low gap ends the frame. Each
//   completed pixel produces one write strobe into the pixel buffer.
//   Optional build macro NEOPIXEL_RX_ERR_CNT_EN adds err_count / last_err.
// Ports:
//   clk7mhz      in  system clock
//   rst_n        in  asynchronous active-low reset
//   neo_in       in  asynchronous serial input
//   rx_en        in  receiver enable; low forces SYNC
//   pixel_valid  out one-cycle pixel write strobe
//   pixel_index  out buffer address of pixel_data
//   pixel_data   out {B,R,G}
//   frame_done   out one-cycle pulse at a valid end of frame
//   pixel_count  out pixels in the last completed frame
//   rx_error     out sticky error; cleared by frame_done of a clean frame
//   err_count    out (optional) saturating error-event count
//   last_err     out (optional) code of the most recent error
module anton_neopixel_rx
  import anton_neopixel_rx_pkg::*;
#(
  parameter int BUFFER_END = 31,
  parameter int T_ONE_MIN  = 4,
  parameter int T_HIGH_MAX = 7,
  parameter int T_RESET    = 350,
  localparam int PIX_BITS  = clog2(BUFFER_END + 1),
  localparam int CNT_BITS  = clog2(T_RESET + 1)
) (
  input  logic                clk7mhz,
  input  logic                rst_n,
  input  logic                neo_in,
  input  logic                rx_en,
  output logic                pixel_valid,
  output logic [PIX_BITS-1:0] pixel_index,
  output logic [23:0]         pixel_data,
  output logic                frame_done,
  output logic [PIX_BITS:0]   pixel_count,
  output logic                rx_error
`ifdef NEOPIXEL_RX_ERR_CNT_EN
  ,
  output logic [7:0]          err_count,
  output logic [1:0]          last_err
`endif
);

  localparam logic [CNT_BITS-1:0] CNT_ONE_C    = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX_C    = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] ONE_MIN_C    = CNT_BITS'(T_ONE_MIN);
  localparam logic [CNT_BITS-1:0] HIGH_MAX_C   = CNT_BITS'(T_HIGH_MAX);
  // Low-count value in the cycle that is the T_RESET-th low clock.
  localparam logic [CNT_BITS-1:0] RESET_LAST_C = CNT_BITS'(T_RESET - 1);
  localparam logic [PIX_BITS:0]   PIX_ONE_C    = (PIX_BITS + 1)'(1);
  localparam logic [PIX_BITS:0]   PIX_LAST_C   = (PIX_BITS + 1)'(BUFFER_END);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] value);
    if (value == CNT_MAX_C) begin
      return value;
    end else begin
      return value + CNT_ONE_C;
    end
  endfunction

  logic level_s;
  logic rise_s;
  logic fall_s;

  rx_state_t state_r;
  rx_state_t state_nxt_s;

  logic [CNT_BITS-1:0] hcnt_r;
  logic [CNT_BITS-1:0] lcnt_r;
  logic [22:0]         shift_r;
  logic [4:0]          bit_cnt_r;
  logic [PIX_BITS:0]   pix_r;
  logic                frame_err_r;

  logic        sync_done_s;
  logic        start_s;
  logic        long_high_s;
  logic        bit_s;
  logic        bit_val_s;
  logic        pix_done_s;
  logic        ovf_s;
  logic        low_rise_s;
  logic        frame_end_s;
  logic        frame_ok_s;
  logic        partial_s;
  logic [23:0] shift_in_s;

  anton_sync_edge u_sync_edge (
    .clk   (clk7mhz),
    .rst_n (rst_n),
    .din   (neo_in),
    .level (level_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // FSM state register.
  always_ff @(posedge clk7mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ENUM_RX_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (!rx_en) begin
      state_nxt_s = ENUM_RX_SYNC;
    end else begin
      case (state_r)
        ENUM_RX_SYNC: begin
          if (sync_done_s) state_nxt_s = ENUM_RX_IDLE;
          else             state_nxt_s = ENUM_RX_SYNC;
        end
        ENUM_RX_IDLE: begin
          if (start_s) state_nxt_s = ENUM_RX_HIGH;
          else         state_nxt_s = ENUM_RX_IDLE;
        end
        ENUM_RX_HIGH: begin
          if (long_high_s) state_nxt_s = ENUM_RX_SYNC;
          else if (bit_s)  state_nxt_s = ENUM_RX_LOW;
          else             state_nxt_s = ENUM_RX_HIGH;
        end
        ENUM_RX_LOW: begin
          if (low_rise_s)       state_nxt_s = ENUM_RX_HIGH;
          else if (frame_end_s) state_nxt_s = ENUM_RX_IDLE;
          else                  state_nxt_s = ENUM_RX_LOW;
        end
        default: state_nxt_s = ENUM_RX_SYNC;
      endcase
    end
  end

  // FSM output decode: per-cycle events consumed by the datapath.
  always_comb begin
    sync_done_s = 1'b0;
    start_s     = 1'b0;
    long_high_s = 1'b0;
    bit_s       = 1'b0;
    low_rise_s  = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      ENUM_RX_SYNC: sync_done_s = rx_en & ~level_s & (lcnt_r >= RESET_LAST_C);
      ENUM_RX_IDLE: start_s     = rx_en & rise_s;
      ENUM_RX_HIGH: begin
        // Over-long check wins over a fall arriving in the same cycle.
        long_high_s = rx_en & (hcnt_r > HIGH_MAX_C);
        bit_s       = rx_en & fall_s & ~(hcnt_r > HIGH_MAX_C);
      end
      ENUM_RX_LOW: begin
        // A rise in the cycle the gap would reach T_RESET keeps the frame.
        low_rise_s  = rx_en & rise_s;
        frame_end_s = rx_en & ~rise_s & (lcnt_r >= RESET_LAST_C);
      end
      default: begin
        sync_done_s = 1'b0;
      end
    endcase
    bit_val_s  = (hcnt_r >= ONE_MIN_C);
    shift_in_s = {shift_r, bit_val_s};
    pix_done_s = bit_s & (bit_cnt_r == BIT_LAST);
    ovf_s      = pix_done_s & (pix_r > PIX_LAST_C);
    frame_ok_s = frame_end_s & (bit_cnt_r == 5'd0);
    partial_s  = frame_end_s & (bit_cnt_r != 5'd0);
  end

  // Datapath: width counters, bit assembly, pixel strobe and frame status.
  always_ff @(posedge clk7mhz or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r      <= '0;
      lcnt_r      <= '0;
      shift_r     <= 23'd0;
      bit_cnt_r   <= 5'd0;
      pix_r       <= '0;
      frame_err_r <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      pixel_data  <= 24'd0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      rx_error    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (!rx_en) begin
        // Drop any partial pixel; SYNC restarts its low count from zero.
        hcnt_r    <= '0;
        lcnt_r    <= '0;
        bit_cnt_r <= 5'd0;
      end else begin
        case (state_r)
          ENUM_RX_SYNC: begin
            if (level_s) lcnt_r <= '0;
            else         lcnt_r <= sat_inc(lcnt_r);
          end
          ENUM_RX_IDLE: begin
            if (start_s) begin
              hcnt_r      <= CNT_ONE_C;
              bit_cnt_r   <= 5'd0;
              pix_r       <= '0;
              frame_err_r <= 1'b0;
            end
          end
          ENUM_RX_HIGH: begin
            if (long_high_s) begin
              rx_error    <= 1'b1;
              frame_err_r <= 1'b1;
              lcnt_r      <= '0;
              bit_cnt_r   <= 5'd0;
            end else if (bit_s) begin
              shift_r <= shift_in_s[22:0];
              lcnt_r  <= CNT_ONE_C;
              if (pix_done_s) begin
                bit_cnt_r <= 5'd0;
                if (ovf_s) begin
                  // Buffer full: pixel decoded but not written; pix stays saturated.
                  rx_error    <= 1'b1;
                  frame_err_r <= 1'b1;
                end else begin
                  pixel_valid <= 1'b1;
                  pixel_index <= pix_r[PIX_BITS-1:0];
                  pixel_data  <= wire_to_brg(shift_in_s);
                  pix_r       <= pix_r + PIX_ONE_C;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
              end
            end else begin
              hcnt_r <= sat_inc(hcnt_r);
            end
          end
          ENUM_RX_LOW: begin
            if (low_rise_s) begin
              hcnt_r <= CNT_ONE_C;
            end else if (frame_end_s) begin
              lcnt_r    <= '0;
              bit_cnt_r <= 5'd0;
              if (frame_ok_s) begin
                frame_done  <= 1'b1;
                pixel_count <= pix_r;
                if (!frame_err_r) rx_error <= 1'b0;
              end else begin
                rx_error    <= 1'b1;
                frame_err_r <= 1'b1;
              end
            end else begin
              lcnt_r <= sat_inc(lcnt_r);
            end
          end
          default: begin
            lcnt_r <= '0;
          end
        endcase
      end
    end
  end

`ifdef NEOPIXEL_RX_ERR_CNT_EN
  logic       err_evt_s;
  logic [1:0] err_code_s;

  // Classify this cycle's error event, if any.
  always_comb begin
    err_evt_s  = 1'b0;
    err_code_s = ERR_NONE;
    if (long_high_s) begin
      err_evt_s  = 1'b1;
      err_code_s = ERR_LONG_HIGH;
    end else if (partial_s) begin
      err_evt_s  = 1'b1;
      err_code_s = ERR_PARTIAL;
    end else if (ovf_s) begin
      err_evt_s  = 1'b1;
      err_code_s = ERR_OVERFLOW;
    end else begin
      err_evt_s  = 1'b0;
      err_code_s = ERR_NONE;
    end
  end

  // Saturating error-event counter and last error code.
  always_ff @(posedge clk7mhz or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
      last_err  <= ERR_NONE;
    end else if (err_evt_s) begin
      last_err <= err_code_s;
      if (err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
